full_adder_bist: RTL and testbench
==================================

// Module: full_adder_bist
// PURPOSE
//  Built-in self-test engine for the 1-bit full adder (sum x, carry y). It drives the
//  adder's a/b/c inputs through all 8 input vectors, samples x/y after a settle window,
//  compares them with an internal golden model and reports pass/fail, an error count and
//  the first failing vector. It sits beside the adder instance in synthesizable designs.
// PARAMETERS
//  SETTLE_CYCLES  1  clocks each vector is held before sampling (>=1)
//  ERR_W          4  width of the error counter (saturating)
// PORTS
//  clk             in   1      single clock, rising edge
//  rst             in   1      reset, asynchronous, active-high
//  start           in   1      1-cycle request to run; accepted only in IDLE or DONE
//  x               in   1      sum returned by adder under test
//  y               in   1      carry returned by adder under test
//  a, b, c         out  1 each registered stimulus to adder under test
//  busy            out  1      high in SETTLE/CHECK
//  done            out  1      high in DONE, held until next start or reset
//  pass            out  1      valid when done: 1 iff err_cnt==0
//  err_cnt         out  ERR_W  mismatching vectors, saturates at 2**ERR_W-1
//  first_fail_vec  out  3      index {a,b,c} of first mismatch; 0 if none
//  fail_map        out  8      per-vector mismatch bitmap (FA_BIST_LOG_EN only)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; a=b=c=0; busy=done=pass=0; err_cnt=0;
//    first_fail_vec=0; fail_map=0; vec=0; settle cnt=0.
//  - States IDLE, SETTLE, CHECK, DONE. Vector index vec[2:0]: a=vec[2],b=vec[1],c=vec[0];
//    order 000..111 ascending.
//  - IDLE/DONE + start: clear err_cnt, first_fail_vec, fail_map, pass, done; vec=0;
//    a,b,c=000; -> SETTLE. start in SETTLE/CHECK is ignored.
//  - SETTLE: hold a,b,c; count SETTLE_CYCLES clocks, then -> CHECK.
//  - CHECK (1 clock): golden sum=a^b^c, carry=ab|bc|ac. Mismatch on x or y: err_cnt+1
//    (saturating); if first mismatch, first_fail_vec=vec; fail_map[vec]=1.
//    vec==7 -> DONE (pass = no mismatch incl. this one); else vec+1, drive new a,b,c, -> SETTLE.
//  - Latency: done rises 8*(SETTLE_CYCLES+1) clocks after the edge that samples start.
//  - DONE: a,b,c keep 111; results stable until start or rst.
//  - x/y are sampled only in CHECK; X on x/y in other states has no effect.
//  - Counter saturation: err_cnt never wraps; pass derives from a separate any-fail flag,
//    not from err_cnt, so pass is correct even when saturated.
// CONFIGURATION
//  FA_BIST_LOG_EN defined: fail_map register implemented as above.
//  Not defined: fail_map tied to 8'h00, no storage; all other behaviour identical.
// STRUCTURE
//  Package fa_bist_pkg: state enum (IDLE,SETTLE,CHECK,DONE), NUM_VECTORS=8, VEC_W=3.
//  Sub-module fa_bist_golden: combinational reference sum/carry from a,b,c.
//  Top holds FSM, settle counter, vector counter, result registers.
// TESTING
//  1 Correct adder looped back, SETTLE_CYCLES=1, start pulse -> done at clock 16,
//    pass=1, err_cnt=0, first_fail_vec=0, fail_map=8'h00; a,b,c sweep 000..111.
//  2 Carry stuck-at-0 -> err_cnt=4, first_fail_vec=3, fail_map=8'hE8, pass=0.
//  3 Sum inverted -> err_cnt=8, first_fail_vec=0, fail_map=8'hFF; with ERR_W=2 err_cnt=3,
//    pass=0.
//  4 start pulsed again at vector 2 during run -> ignored; done still at clock 16.
//  5 rst asserted mid-run (vec=4, SETTLE) -> all outputs reset values immediately; new
//    start runs full sweep, results as scenario 1.
//  6 Faulty run then correct adder + start from DONE -> counters cleared, pass=1;
//    SETTLE_CYCLES=3 -> done at clock 32.

Source files
------------

// File: rtl/fa_bist_pkg.sv
// rtl/fa_bist_pkg.sv - shared types and constants for the full adder BIST engine
// Purpose: state encoding and vector-space constants used by full_adder_bist.
// Ports: none (package).
package fa_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int NUM_VECTORS = 8;
  localparam int VEC_W       = 3;

endpackage

// File: rtl/fa_bist_golden.sv
// rtl/fa_bist_golden.sv - combinational reference model of a 1-bit full adder
// Purpose: golden sum/carry used by the BIST engine to judge the adder under test.
// Ports:
//   a, b, c  in   adder operands and carry-in
//   sum      out  a ^ b ^ c
//   carry    out  majority(a, b, c)
module fa_bist_golden
  import fa_bist_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (b & c) | (a & c);

endmodule

// File: rtl/full_adder_bist.sv
// rtl/full_adder_bist.sv - built-in self-test engine for a 1-bit full adder
// Purpose: sweeps a/b/c through all 8 vectors, holds each for SETTLE_CYCLES clocks,
//   samples x/y for one CHECK clock, compares with fa_bist_golden and reports results.
// Optional feature: define FA_BIST_LOG_EN to implement the fail_map register;
//   otherwise fail_map is tied to 8'h00.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start           1-cycle run request, honoured only in IDLE or DONE
//   x, y            sum / carry returned by the adder under test
//   a, b, c         registered stimulus ({a,b,c} = vector index)
//   busy, done      busy in SETTLE/CHECK, done held in DONE
//   pass            1 iff no vector mismatched (valid when done)
//   err_cnt         saturating count of mismatching vectors
//   first_fail_vec  index of the first mismatching vector, 0 if none
//   fail_map        per-vector mismatch bitmap
module full_adder_bist
  import fa_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,  // must be >= 1
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             x,
  input  logic             y,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       first_fail_vec,
  output logic [7:0]       fail_map
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             any_fail_q, any_fail_d;
  logic [2:0]       ffv_q, ffv_d;
  logic             pass_q, pass_d;

  logic gold_sum, gold_carry;
  logic settle_last;
  logic mismatch;

  fa_bist_golden u_golden (
    .a     (vec_q[2]),
    .b     (vec_q[1]),
    .c     (vec_q[0]),
    .sum   (gold_sum),
    .carry (gold_carry)
  );

  assign settle_last = (cnt_q == SETTLE_LAST);
  // Gated by CHECK so unknowns on x/y outside the sample window cannot leak in.
  assign mismatch = (state_q == CHECK) && ((x != gold_sum) || (y != gold_carry));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = SETTLE;
      SETTLE:     if (settle_last) state_d = CHECK;
      CHECK:      state_d = (vec_q == LAST_VEC) ? DONE : SETTLE;
      default:    state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      SETTLE, CHECK: busy = 1'b1;
      DONE:          done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values
  always_comb begin
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    any_fail_d = any_fail_q;
    ffv_d      = ffv_q;
    pass_d     = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          vec_d      = '0;
          cnt_d      = '0;
          err_d      = '0;
          any_fail_d = 1'b0;
          ffv_d      = '0;
          pass_d     = 1'b0;
        end
      end
      SETTLE: begin
        cnt_d = settle_last ? '0 : cnt_q + 1'b1;
      end
      CHECK: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) err_d = err_q + 1'b1;
          if (!any_fail_q) ffv_d = vec_q;
          any_fail_d = 1'b1;
        end
        // pass comes from the any-fail flag so a saturated counter cannot mislead it.
        if (vec_q == LAST_VEC) begin
          pass_d = !(any_fail_q || mismatch);
        end else begin
          vec_d = vec_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q      <= '0;
      cnt_q      <= '0;
      err_q      <= '0;
      any_fail_q <= 1'b0;
      ffv_q      <= '0;
      pass_q     <= 1'b0;
    end else begin
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      any_fail_q <= any_fail_d;
      ffv_q      <= ffv_d;
      pass_q     <= pass_d;
    end
  end

`ifdef FA_BIST_LOG_EN
  logic [7:0] map_q, map_d;

  always_comb begin
    map_d = map_q;
    if ((state_q == IDLE || state_q == DONE) && start) begin
      map_d = '0;
    end else if (mismatch) begin
      map_d[vec_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      map_q <= '0;
    end else begin
      map_q <= map_d;
    end
  end

  assign fail_map = map_q;
`else
  assign fail_map = 8'h00;
`endif

  // Stimulus is the registered vector index itself.
  assign a              = vec_q[2];
  assign b              = vec_q[1];
  assign c              = vec_q[0];
  assign pass           = pass_q;
  assign err_cnt        = err_q;
  assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_full_adder_bist.sv
// tb/tb_full_adder_bist.sv - directed self-checking bench for full_adder_bist
module tb_full_adder_bist;

`ifdef FA_BIST_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance 1: default parameters
  logic       start = 1'b0;
  logic [1:0] mode  = 2'd0;  // 0 correct, 1 carry stuck-at-0, 2 sum inverted
  logic       x, y, a, b, c, busy, done, pass;
  logic [3:0] err_cnt;
  logic [2:0] ffv;
  logic [7:0] fail_map;

  // Instance 2: SETTLE_CYCLES=3, ERR_W=2
  logic       start2 = 1'b0;
  logic [1:0] mode2  = 2'd0;
  logic       x2, y2, a2, b2, c2, busy2, done2, pass2;
  logic [1:0] err_cnt2;
  logic [2:0] ffv2;
  logic [7:0] fail_map2;

  assign x  = a ^ b ^ c ^ (mode == 2'd2);
  assign y  = (mode == 2'd1) ? 1'b0 : ((a & b) | (b & c) | (a & c));
  assign x2 = a2 ^ b2 ^ c2 ^ (mode2 == 2'd2);
  assign y2 = (mode2 == 2'd1) ? 1'b0 : ((a2 & b2) | (b2 & c2) | (a2 & c2));

  full_adder_bist #(.SETTLE_CYCLES(1), .ERR_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_fail_vec(ffv), .fail_map(fail_map)
  );

  full_adder_bist #(.SETTLE_CYCLES(3), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .x(x2), .y(y2),
    .a(a2), .b(b2), .c(c2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err_cnt2), .first_fail_vec(ffv2), .fail_map(fail_map2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_map(input logic [7:0] m);
    return LOG_EN ? m : 8'h00;
  endfunction

  // Run instance 1; optionally re-pulse start when vector poke_vec is on a/b/c.
  task automatic run1(input int poke_vec, output int lat, output logic [7:0] seen,
                      output bit order_ok);
    int last;
    bit poked;
    logic [2:0] v;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; seen = 8'h00; last = -1; order_ok = 1'b1; poked = 1'b0;
    while (lat < 200) begin
      v = {a, b, c};
      if (busy) begin
        seen[v] = 1'b1;
        if (int'(v) < last) order_ok = 1'b0;
        last = int'(v);
        if (poke_vec >= 0 && !poked && int'(v) == poke_vec) begin
          start = 1'b1;
          poked = 1'b1;
        end
      end
      @(posedge clk);
      #1 start = 1'b0;
      lat++;
      if (done) break;
    end
  endtask

  task automatic run2(output int lat);
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    lat = 0;
    while (lat < 400) begin
      @(posedge clk);
      #1 lat++;
      if (done2) break;
    end
  endtask

  int lat;
  logic [7:0] seen;
  bit order_ok;
  int guard;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_err", err_cnt, 4'd0);
    check("rst_ffv", ffv, 3'd0);
    check("rst_map", fail_map, 8'h00);
    check("rst_abc", {a, b, c}, 3'b000);
    @(negedge clk) rst = 1'b0;

    // 1: correct adder
    mode = 2'd0;
    run1(-1, lat, seen, order_ok);
    check("s1_latency", lat, 16);
    check("s1_pass", pass, 1'b1);
    check("s1_err", err_cnt, 4'd0);
    check("s1_ffv", ffv, 3'd0);
    check("s1_map", fail_map, exp_map(8'h00));
    check("s1_sweep", seen, 8'hFF);
    check("s1_order", order_ok, 1'b1);
    check("s1_abc_done", {a, b, c}, 3'b111);
    check("s1_busy_done", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("s1_done_held", done, 1'b1);

    // 2: carry stuck-at-0
    mode = 2'd1;
    run1(-1, lat, seen, order_ok);
    check("s2_latency", lat, 16);
    check("s2_err", err_cnt, 4'd4);
    check("s2_ffv", ffv, 3'd3);
    check("s2_map", fail_map, exp_map(8'hE8));
    check("s2_pass", pass, 1'b0);

    // 3: sum inverted
    mode = 2'd2;
    run1(-1, lat, seen, order_ok);
    check("s3_err", err_cnt, 4'd8);
    check("s3_ffv", ffv, 3'd0);
    check("s3_map", fail_map, exp_map(8'hFF));
    check("s3_pass", pass, 1'b0);

    // 6a: correct adder restarted from DONE clears results
    mode = 2'd0;
    run1(-1, lat, seen, order_ok);
    check("s6_pass", pass, 1'b1);
    check("s6_err", err_cnt, 4'd0);
    check("s6_ffv", ffv, 3'd0);
    check("s6_map", fail_map, exp_map(8'h00));

    // 4: start re-pulsed at vector 2 is ignored
    run1(2, lat, seen, order_ok);
    check("s4_latency", lat, 16);
    check("s4_sweep", seen, 8'hFF);
    check("s4_order", order_ok, 1'b1);
    check("s4_pass", pass, 1'b1);

    // 5: reset mid-run in SETTLE of vector 4 (faulty carry so results are non-zero)
    mode = 2'd1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    guard = 0;
    while (!(busy && {a, b, c} == 3'b100 && dut.state_q == fa_bist_pkg::SETTLE) && guard < 100) begin
      @(posedge clk);
      #1 guard++;
    end
    check("s5_reach_vec4", guard < 100, 1'b1);
    check("s5_err_before", err_cnt, 4'd1);
    rst = 1'b1;
    #1;
    check("s5_rst_busy", busy, 1'b0);
    check("s5_rst_done", done, 1'b0);
    check("s5_rst_pass", pass, 1'b0);
    check("s5_rst_err", err_cnt, 4'd0);
    check("s5_rst_ffv", ffv, 3'd0);
    check("s5_rst_map", fail_map, 8'h00);
    check("s5_rst_abc", {a, b, c}, 3'b000);
    @(negedge clk) rst = 1'b0;
    mode = 2'd0;
    run1(-1, lat, seen, order_ok);
    check("s5_latency", lat, 16);
    check("s5_sweep", seen, 8'hFF);
    check("s5_pass", pass, 1'b1);
    check("s5_err", err_cnt, 4'd0);

    // Instance 2: saturation at ERR_W=2 and SETTLE_CYCLES=3 latency
    mode2 = 2'd2;
    run2(lat);
    check("i2_fault_latency", lat, 32);
    check("i2_err_sat", err_cnt2, 2'd3);
    check("i2_pass", pass2, 1'b0);
    check("i2_ffv", ffv2, 3'd0);
    check("i2_map", fail_map2, exp_map(8'hFF));
    mode2 = 2'd0;
    run2(lat);
    check("i2_good_latency", lat, 32);
    check("i2_good_pass", pass2, 1'b1);
    check("i2_good_err", err_cnt2, 2'd0);
    check("i2_abc_done", {a2, b2, c2}, 3'b111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
